// File: rtl/ifu_fetch_if.sv
// Fetch-unit bus bundle: instruction-memory request/return, redirect input and decode handshake.
// The misalignment report signals exist only when IFU_MISALIGN_CHK_EN is defined.
interface ifu_fetch_if;
  logic [31:0] o_imem_addr;
  logic [31:0] i_imem_data;
  logic        i_redirect_valid;
  logic [31:0] i_redirect_pc;
  logic        o_inst_valid;
  logic        i_inst_ready;
  logic [31:0] o_inst;
  logic [31:0] o_inst_pc;
`ifdef IFU_MISALIGN_CHK_EN
  logic        o_misalign;
  logic [31:0] o_misalign_pc;

  modport master (
    output o_imem_addr, o_inst_valid, o_inst, o_inst_pc, o_misalign, o_misalign_pc,
    input  i_imem_data, i_redirect_valid, i_redirect_pc, i_inst_ready
  );
  modport slave (
    input  o_imem_addr, o_inst_valid, o_inst, o_inst_pc, o_misalign, o_misalign_pc,
    output i_imem_data, i_redirect_valid, i_redirect_pc, i_inst_ready
  );
`else
  modport master (
    output o_imem_addr, o_inst_valid, o_inst, o_inst_pc,
    input  i_imem_data, i_redirect_valid, i_redirect_pc, i_inst_ready
  );
  modport slave (
    input  o_imem_addr, o_inst_valid, o_inst, o_inst_pc,
    output i_imem_data, i_redirect_valid, i_redirect_pc, i_inst_ready
  );
`endif
endinterface

// File: rtl/ifu_fetch.sv
// Instruction-fetch initiator: issues word fetches, buffers returns with their PCs, flushes on redirect.
// Optional IFU_MISALIGN_CHK_EN: flags misaligned redirect targets and blocks fetching while flagged.
module ifu_fetch #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic         clk,
  input logic         rst_n,
  ifu_fetch_if.master bus
);
  localparam int PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   fpc_r;
  logic          inflight_r;
  logic [31:0]   inflight_pc_r;
  logic [31:0]   inst_mem_r [DEPTH];
  logic [31:0]   pc_mem_r   [DEPTH];
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] wr_ptr_r;
  logic [CW-1:0] count_r;

  logic [31:0]   addr_s;
  logic [CW:0]   occ_s;
  logic          redirect_ok_s;
  logic          blocked_s;
  logic          issue_s;
  logic          push_s;
  logic          valid_s;
  logic          pop_s;
  logic [31:0]   head_inst_s;
  logic [31:0]   head_pc_s;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1);
    end
  endfunction

`ifdef IFU_MISALIGN_CHK_EN
  logic        misalign_r;
  logic [31:0] misalign_pc_r;

  // Misaligned redirect targets are not fetched; the flag holds fetch off until an aligned redirect
  always_comb begin
    redirect_ok_s = (bus.i_redirect_pc[1:0] == 2'b00);
    blocked_s     = misalign_r;
  end

  // Sticky misalignment report, updated only by redirects
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_r    <= 1'b0;
      misalign_pc_r <= 32'h0000_0000;
    end else if (bus.i_redirect_valid) begin
      misalign_r <= ~redirect_ok_s;
      if (!redirect_ok_s) begin
        misalign_pc_r <= bus.i_redirect_pc;
      end
    end
  end

  assign bus.o_misalign    = misalign_r;
  assign bus.o_misalign_pc = misalign_pc_r;
`else
  // Without the checker every redirect target is fetched as-is
  always_comb begin
    redirect_ok_s = 1'b1;
    blocked_s     = 1'b0;
  end
`endif

  // Address select, issue credit, FIFO push/pop and head read
  always_comb begin
    addr_s      = fpc_r;
    occ_s       = (CW + 1)'(count_r) + (CW + 1)'(inflight_r);
    issue_s     = 1'b0;
    head_inst_s = 32'h0000_0000;
    head_pc_s   = 32'h0000_0000;
    if (bus.i_redirect_valid) begin
      addr_s  = bus.i_redirect_pc;
      issue_s = redirect_ok_s;
    end else begin
      addr_s  = fpc_r;
      // A same-cycle pop is deliberately not credited
      issue_s = (occ_s < (CW + 1)'(DEPTH)) & ~blocked_s;
    end
    push_s  = inflight_r & ~bus.i_redirect_valid;
    valid_s = (count_r != {CW{1'b0}}) & ~bus.i_redirect_valid;
    pop_s   = valid_s & bus.i_inst_ready;
    if (count_r != {CW{1'b0}}) begin
      head_inst_s = inst_mem_r[rd_ptr_r];
      head_pc_s   = pc_mem_r[rd_ptr_r];
    end else begin
      head_inst_s = 32'h0000_0000;
      head_pc_s   = 32'h0000_0000;
    end
  end

  // Fetch PC and single outstanding request tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpc_r         <= RESET_PC;
      inflight_r    <= 1'b0;
      inflight_pc_r <= 32'h0000_0000;
    end else if (issue_s) begin
      fpc_r         <= addr_s + 32'd4;
      inflight_r    <= 1'b1;
      inflight_pc_r <= addr_s;
    end else begin
      // addr_s is fpc_r unless a non-fetching redirect parks the PC at its target
      fpc_r      <= addr_s;
      inflight_r <= 1'b0;
    end
  end

  // FIFO pointers and occupancy; a redirect drops everything buffered and returning
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (bus.i_redirect_valid) begin
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= next_ptr(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= next_ptr(rd_ptr_r);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // FIFO storage: returned instruction paired with the PC it was fetched from
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        inst_mem_r[i] <= 32'h0000_0000;
        pc_mem_r[i]   <= 32'h0000_0000;
      end
    end else if (push_s) begin
      inst_mem_r[wr_ptr_r] <= bus.i_imem_data;
      pc_mem_r[wr_ptr_r]   <= inflight_pc_r;
    end
  end

  assign bus.o_imem_addr  = addr_s;
  assign bus.o_inst_valid = valid_s;
  assign bus.o_inst       = head_inst_s;
  assign bus.o_inst_pc    = head_pc_s;

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: directed scenarios plus random redirect/backpressure
// checked against a queue-based model of the delivered instruction stream.
module tb_ifu_fetch;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  ifu_fetch_if bus ();

  ifu_fetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return (w * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  // Instruction memory: registered read, word addressed
  always @(posedge clk) bus.i_imem_data <= imem_word(bus.o_imem_addr);

  // Occupancy must never exceed DEPTH
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      n_checks++;
      if (dut.count_r > DEPTH) begin
        n_fail++;
        $display("FAIL overflow count=%0d limit=%0d", dut.count_r, DEPTH);
      end
    end
  end

  // Reference model: PCs buffered for decode, the one outstanding fetch, next fetch PC
  logic [31:0] mq[$];
  bit          m_pend;
  logic [31:0] m_ppc;
  logic [31:0] m_npc;
  bit          m_mis;
  logic [31:0] m_mispc;
  logic [31:0] e_addr;
  logic        e_valid;
  logic [31:0] e_inst;
  logic [31:0] e_pc;

  task automatic model_reset();
    mq.delete();
    m_pend  = 1'b0;
    m_ppc   = 32'h0;
    m_npc   = RESET_PC;
    m_mis   = 1'b0;
    m_mispc = 32'h0;
  endtask

  task automatic model_outputs();
    e_addr  = bus.i_redirect_valid ? bus.i_redirect_pc : m_npc;
    e_valid = (mq.size() != 0) && !bus.i_redirect_valid;
    e_pc    = (mq.size() != 0) ? mq[0] : 32'h0;
    e_inst  = (mq.size() != 0) ? imem_word(mq[0]) : 32'h0;
  endtask

  task automatic model_step();
    bit can_fetch;
    bit bad;
    model_outputs();
`ifdef IFU_MISALIGN_CHK_EN
    bad = (bus.i_redirect_pc[1:0] != 2'b00);
`else
    bad = 1'b0;
`endif
    if (bus.i_redirect_valid) begin
      mq.delete();
      if (bad) begin
        m_mis = 1'b1; m_mispc = bus.i_redirect_pc; m_pend = 1'b0; m_npc = bus.i_redirect_pc;
      end else begin
        m_mis = 1'b0; m_pend = 1'b1; m_ppc = bus.i_redirect_pc; m_npc = bus.i_redirect_pc + 32'd4;
      end
    end else begin
      can_fetch = ((mq.size() + int'(m_pend)) < DEPTH) && !m_mis;
      if (e_valid && bus.i_inst_ready) void'(mq.pop_front());
      if (m_pend) mq.push_back(m_ppc);
      if (can_fetch) begin
        m_pend = 1'b1; m_ppc = m_npc; m_npc = m_npc + 32'd4;
      end else begin
        m_pend = 1'b0;
      end
    end
  endtask

  task automatic drive(input logic redir, input logic [31:0] rpc, input logic rdy);
    bus.i_redirect_valid = redir;
    bus.i_redirect_pc    = rpc;
    bus.i_inst_ready     = rdy;
  endtask

  // Called at posedge+1: advance the model on this cycle's inputs, then move to the next cycle
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 32'h0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    drive(1'b0, 32'h0, 1'b1);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({bus.o_imem_addr, bus.o_inst_valid, bus.o_inst, bus.o_inst_pc} !== {RESET_PC, 1'b0, 32'h0, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_state got addr=%h v=%b inst=%h pc=%h want addr=%h v=0 inst=0 pc=0",
               bus.o_imem_addr, bus.o_inst_valid, bus.o_inst, bus.o_inst_pc, RESET_PC);
    end
  endtask

  task automatic test_stream();
    do_reset();
    drive(1'b0, 32'h0, 1'b1);
    for (int k = 0; k < 12; k++) begin
      #3;
      model_outputs();
      n_checks++;
      if ({bus.o_imem_addr, bus.o_inst_valid, bus.o_inst, bus.o_inst_pc} !== {e_addr, e_valid, e_inst, e_pc}) begin
        n_fail++;
        $display("FAIL stream_model k=%0d got %h/%b/%h/%h want %h/%b/%h/%h", k, bus.o_imem_addr,
                 bus.o_inst_valid, bus.o_inst, bus.o_inst_pc, e_addr, e_valid, e_inst, e_pc);
      end
      n_checks++;
      if (k < 2) begin
        if (bus.o_inst_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL stream_early_valid k=%0d got %b want 0", k, bus.o_inst_valid);
        end
      end else if ({bus.o_imem_addr, bus.o_inst_valid, bus.o_inst_pc} !==
                   {RESET_PC + 32'(4 * k), 1'b1, RESET_PC + 32'(4 * (k - 2))}) begin
        n_fail++;
        $display("FAIL stream_seq k=%0d got addr=%h v=%b pc=%h want addr=%h v=1 pc=%h", k, bus.o_imem_addr,
                 bus.o_inst_valid, bus.o_inst_pc, RESET_PC + 32'(4 * k), RESET_PC + 32'(4 * (k - 2)));
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] got[$];
    do_reset();
    drive(1'b0, 32'h0, 1'b0);
    for (int k = 0; k < 16; k++) begin
      if (k == 8) drive(1'b0, 32'h0, 1'b1);
      #3;
      model_outputs();
      n_checks++;
      if ({bus.o_imem_addr, bus.o_inst_valid, bus.o_inst, bus.o_inst_pc} !== {e_addr, e_valid, e_inst, e_pc}) begin
        n_fail++;
        $display("FAIL backpressure_model k=%0d got %h/%b/%h/%h want %h/%b/%h/%h", k, bus.o_imem_addr,
                 bus.o_inst_valid, bus.o_inst, bus.o_inst_pc, e_addr, e_valid, e_inst, e_pc);
      end
      if (k == 7) begin
        n_checks++;
        if ({bus.o_imem_addr, bus.o_inst_valid, bus.o_inst_pc} !== {32'h0000_0010, 1'b1, 32'h0000_0000}) begin
          n_fail++;
          $display("FAIL backpressure_hold got addr=%h v=%b pc=%h want addr=00000010 v=1 pc=00000000",
                   bus.o_imem_addr, bus.o_inst_valid, bus.o_inst_pc);
        end
      end
      if (bus.o_inst_valid === 1'b1 && bus.i_inst_ready === 1'b1) got.push_back(bus.o_inst_pc);
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (i >= got.size()) begin
        n_fail++;
        $display("FAIL drain_order idx=%0d got none want %h", i, 32'(4 * i));
      end else if (got[i] !== 32'(4 * i)) begin
        n_fail++;
        $display("FAIL drain_order idx=%0d got %h want %h", i, got[i], 32'(4 * i));
      end
    end
  endtask

  task automatic test_redirect_full();
    do_reset();
    drive(1'b0, 32'h0, 1'b0);
    repeat (6) tick();
    for (int k = 0; k < 5; k++) begin
      drive(k == 0, 32'h0000_0100, 1'b1);
      #3;
      model_outputs();
      n_checks++;
      if ({bus.o_imem_addr, bus.o_inst_valid, bus.o_inst, bus.o_inst_pc} !== {e_addr, e_valid, e_inst, e_pc}) begin
        n_fail++;
        $display("FAIL redirect_model k=%0d got %h/%b/%h/%h want %h/%b/%h/%h", k, bus.o_imem_addr,
                 bus.o_inst_valid, bus.o_inst, bus.o_inst_pc, e_addr, e_valid, e_inst, e_pc);
      end
      n_checks++;
      if (k < 2) begin
        if (bus.o_inst_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL redirect_bubble t+%0d got v=%b want 0", k, bus.o_inst_valid);
        end
      end else if ({bus.o_inst_valid, bus.o_inst_pc, bus.o_inst} !==
                   {1'b1, 32'h0000_0100 + 32'(4 * (k - 2)), imem_word(32'h0000_0100 + 32'(4 * (k - 2)))}) begin
        n_fail++;
        $display("FAIL redirect_target t+%0d got v=%b pc=%h inst=%h want v=1 pc=%h", k, bus.o_inst_valid,
                 bus.o_inst_pc, bus.o_inst, 32'h0000_0100 + 32'(4 * (k - 2)));
      end
      tick();
    end
  endtask

  task automatic test_back_to_back_redirect();
    do_reset();
    drive(1'b0, 32'h0, 1'b1);
    repeat (4) tick();
    for (int k = 0; k < 8; k++) begin
      drive(k < 2, (k == 0) ? 32'h0000_0200 : 32'h0000_0300, 1'b1);
      #3;
      model_outputs();
      n_checks++;
      if ({bus.o_imem_addr, bus.o_inst_valid, bus.o_inst, bus.o_inst_pc} !== {e_addr, e_valid, e_inst, e_pc}) begin
        n_fail++;
        $display("FAIL b2b_model k=%0d got %h/%b/%h/%h want %h/%b/%h/%h", k, bus.o_imem_addr,
                 bus.o_inst_valid, bus.o_inst, bus.o_inst_pc, e_addr, e_valid, e_inst, e_pc);
      end
      n_checks++;
      if (k < 3) begin
        if (bus.o_inst_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_bubble t+%0d got v=%b want 0", k, bus.o_inst_valid);
        end
      end else if ({bus.o_inst_valid, bus.o_inst_pc} !== {1'b1, 32'h0000_0300 + 32'(4 * (k - 3))}) begin
        n_fail++;
        $display("FAIL b2b_target t+%0d got v=%b pc=%h want v=1 pc=%h", k, bus.o_inst_valid,
                 bus.o_inst_pc, 32'h0000_0300 + 32'(4 * (k - 3)));
      end
      tick();
    end
  endtask

  task automatic test_reset_midstream();
    int guard;
    do_reset();
    drive(1'b0, 32'h0, 1'b0);
    guard = 0;
    while (mq.size() != 3 && guard < 20) begin
      tick();
      guard++;
    end
    n_checks++;
    if (mq.size() != 3) begin
      n_fail++;
      $display("FAIL midreset_setup got occupancy=%0d want 3", mq.size());
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.o_imem_addr, bus.o_inst_valid, bus.o_inst, bus.o_inst_pc} !== {RESET_PC, 1'b0, 32'h0, 32'h0}) begin
      n_fail++;
      $display("FAIL midreset_async got addr=%h v=%b inst=%h pc=%h want addr=%h v=0 inst=0 pc=0",
               bus.o_imem_addr, bus.o_inst_valid, bus.o_inst, bus.o_inst_pc, RESET_PC);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    drive(1'b0, 32'h0, 1'b1);
    for (int k = 0; k < 6; k++) begin
      #3;
      model_outputs();
      n_checks++;
      if ({bus.o_imem_addr, bus.o_inst_valid, bus.o_inst, bus.o_inst_pc} !== {e_addr, e_valid, e_inst, e_pc}) begin
        n_fail++;
        $display("FAIL midreset_restart k=%0d got %h/%b/%h/%h want %h/%b/%h/%h", k, bus.o_imem_addr,
                 bus.o_inst_valid, bus.o_inst, bus.o_inst_pc, e_addr, e_valid, e_inst, e_pc);
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic        redir;
    logic [31:0] rpc;
    do_reset();
    for (int k = 0; k < 600; k++) begin
      redir = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 5))
        0:       rpc = 32'hFFFF_FFF8;
        1:       rpc = $urandom;
        default: rpc = $urandom & 32'h0000_FFFC;
      endcase
      drive(redir, rpc, $urandom_range(0, 3) != 0);
      #3;
      model_outputs();
      n_checks++;
      if ({bus.o_imem_addr, bus.o_inst_valid, bus.o_inst, bus.o_inst_pc} !== {e_addr, e_valid, e_inst, e_pc}) begin
        n_fail++;
        $display("FAIL random k=%0d got %h/%b/%h/%h want %h/%b/%h/%h", k, bus.o_imem_addr,
                 bus.o_inst_valid, bus.o_inst, bus.o_inst_pc, e_addr, e_valid, e_inst, e_pc);
      end
`ifdef IFU_MISALIGN_CHK_EN
      n_checks++;
      if ({bus.o_misalign, bus.o_misalign_pc} !== {m_mis, m_mispc}) begin
        n_fail++;
        $display("FAIL random_misalign k=%0d got %b/%h want %b/%h", k, bus.o_misalign, bus.o_misalign_pc,
                 m_mis, m_mispc);
      end
`endif
      tick();
    end
  endtask

`ifdef IFU_MISALIGN_CHK_EN
  task automatic test_misalign();
    do_reset();
    drive(1'b0, 32'h0, 1'b1);
    repeat (4) tick();
    drive(1'b1, 32'h0000_0102, 1'b1);
    tick();
    drive(1'b0, 32'h0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      #3;
      n_checks++;
      if ({bus.o_misalign, bus.o_misalign_pc, bus.o_inst_valid} !== {1'b1, 32'h0000_0102, 1'b0}) begin
        n_fail++;
        $display("FAIL misalign_set k=%0d got flag=%b pc=%h v=%b want flag=1 pc=00000102 v=0", k,
                 bus.o_misalign, bus.o_misalign_pc, bus.o_inst_valid);
      end
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      drive(k == 0, 32'h0000_0104, 1'b1);
      #3;
      n_checks++;
      if (k >= 1 && bus.o_misalign !== 1'b0) begin
        n_fail++;
        $display("FAIL misalign_clear t+%0d got %b want 0", k, bus.o_misalign);
      end else if (k >= 2 && {bus.o_inst_valid, bus.o_inst_pc} !== {1'b1, 32'h0000_0104 + 32'(4 * (k - 2))}) begin
        n_fail++;
        $display("FAIL misalign_resume t+%0d got v=%b pc=%h want v=1 pc=%h", k, bus.o_inst_valid,
                 bus.o_inst_pc, 32'h0000_0104 + 32'(4 * (k - 2)));
      end
      tick();
    end
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    model_reset();
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_full();
    test_back_to_back_redirect();
    test_reset_midstream();
`ifdef IFU_MISALIGN_CHK_EN
    test_misalign();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction-fetch initiator that drives the word-addressed instruction memory and consumes its registered read data.
- The instruction memory returns data one clock after the address is presented.
- Tracks the in-flight request, buffers returned instructions with their PCs in a small FIFO, and hands them to decode over a valid/ready handshake.
- Accepts PC redirects from branch/jump resolution: a redirect flushes all buffered and in-flight instructions.

Parameters:
- DEPTH, 4, instruction FIFO entries; minimum 2; DEPTH≥3 sustains 1 instr/cycle.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- o_imem_addr  output  32  byte address to instruction memory; imem uses bits [31:2]
- i_imem_data  input  32  instruction from imem, valid the cycle after its address was issued
- i_redirect_valid  input  1  redirect request, single-cycle
- i_redirect_pc  input  32  redirect target
- o_inst_valid  output  1  FIFO head valid toward decode
- i_inst_ready  input  1  decode accepts head
- o_inst  output  32  head instruction
- o_inst_pc  output  32  head instruction PC

Behaviour:
- State:
  - fpc, the next fetch PC.
  - inflight flag plus inflight_pc.
  - FIFO storage, rd/wr pointers, count in 0..DEPTH.
- Reset (async, rst_n=0):
  - fpc=RESET_PC; inflight=0; count=0; pointers=0.
  - o_inst_valid=0; o_inst=0; o_inst_pc=0.
  - o_imem_addr=RESET_PC.
- Address output:
  - o_imem_addr = i_redirect_valid ? i_redirect_pc : fpc (combinational).
- Issue condition, normal cycle: issue = (count + inflight) < DEPTH. Conservative: a same-cycle pop is not credited.
- On issue:
  - inflight<=1, inflight_pc<=o_imem_addr.
  - fpc<=o_imem_addr+4, mod 2^32; 32'hFFFF_FFFC wraps to 0.
- No issue:
  - fpc holds; inflight<=0.
  - The imem still reads o_imem_addr, but that data is ignored.
- Return:
  - If inflight=1 and no redirect this cycle, write {i_imem_data, inflight_pc} at wr_ptr; wr_ptr++ modulo DEPTH.
  - Data is visible at the head no earlier than the following cycle. There is no bypass.
- Output:
  - o_inst_valid = (count!=0) & ~i_redirect_valid.
  - o_inst/o_inst_pc = head entry; 0 when count=0.
- Pop:
  - Occurs when o_inst_valid & i_inst_ready; rd_ptr++ modulo DEPTH.
  - Simultaneous push+pop leaves count unchanged.
  - Count never exceeds DEPTH, guaranteed by the issue rule. Overflow is a design error; assert it in the bench.
- Redirect (i_redirect_valid=1): top priority.
  - count<=0, pointers reset.
  - In-flight data arriving this cycle is discarded.
  - Pop is suppressed.
  - Issue is forced: inflight<=1, inflight_pc<=i_redirect_pc, fpc<=i_redirect_pc+4.
  - Latency: redirect in cycle t gives the target instruction with o_inst_valid=1 in cycle t+2.
- Redirect while a redirect issue is in flight: the newer redirect wins and the older return is dropped.
- Post-reset latency: first o_inst_valid occurs in the 2nd rising edge after rst_n deasserts, with o_inst_pc=RESET_PC.
- Reset mid-operation: all state clears immediately (asynchronous), and fetch restarts from RESET_PC.

Optional Feature:
- Macro IFU_MISALIGN_CHK_EN.
- When defined:
  - Adds output o_misalign (1 bit), registered, reset 0.
  - Set to 1 the cycle after a redirect with i_redirect_pc[1:0]!=0, capturing the bad PC in o_misalign_pc (32 bit, reset 0).
  - Cleared by the next redirect with aligned target.
  - While set, issue is blocked (no new fetches); the FIFO still drains.
- When undefined:
  - No extra ports.
  - Low address bits are passed through unchecked; the imem ignores them.

Test Plan:
- Reset release, i_inst_ready=1, imem model returns addr-derived data → o_imem_addr 0,4,8,...; o_inst_valid first high 2 cycles after release; o_inst_pc 0,4,8,... one per cycle without bubbles.
- i_inst_ready=0 from start → exactly DEPTH=4 issues (addr 0..C); fpc holds at 0x10; count=4. Ready=1 → pcs 0,4,8,C drain in order, and fetching resumes at 0x10.
- FIFO full (pcs 0..C), redirect to 0x100 → o_inst_valid=0 in redirect cycle and the next cycle; cycle t+2 o_inst_pc=0x100, then 0x104; no old entries appear.
- Redirect to 0x200 at cycle t, redirect to 0x300 at t+1 → 0x200 is never delivered; first valid pc is 0x300 at t+3.
- rst_n pulsed low mid-stream with count=3 → o_inst_valid=0 immediately (async); after release, fetch restarts at RESET_PC.
- With IFU_MISALIGN_CHK_EN: redirect to 0x102 → o_misalign=1, o_misalign_pc=0x102, no further issues; redirect to 0x104 clears o_misalign, and pc 0x104 is delivered at t+2.
